// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm delay scheduler.
// State encodings, timing defaults and the seconds-counter width.
package alarm_pkg;

  localparam int SEC_W        = 4;
  localparam int CLK_HZ_DEF   = 50000000;
  localparam int DELAY_P2_DEF = 5;
  localparam int DELAY_P1_DEF = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    RUN_P2  = 3'b001,
    RUN_P1  = 3'b010,
    DONE_P2 = 3'b011,
    DONE_P1 = 3'b100
  } state_t;

endpackage

// File: rtl/alarm_tick_gen.sv
// Modulo-MOD counter with synchronous clear, count enable
// and a terminal-count pulse on the wrapping cycle.
module alarm_tick_gen #(
  parameter int MOD = 4
) (
  input  logic CLOCK_IN,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLOCK_IN or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/alarm_delay_scheduler.sv
// Shared seconds timer arbitrating the exit delay (P2) and
// siren hold (P1) requests; also produces the 1 Hz strobe clock.
module alarm_delay_scheduler
  import alarm_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEF,
  parameter int DELAY_P2_SEC = DELAY_P2_DEF,
  parameter int DELAY_P1_SEC = DELAY_P1_DEF
) (
  input  logic             CLOCK_IN,
  input  logic             RESET,
  input  logic             ENABLE_COUNT_P2,
  input  logic             ENABLE_COUNT_P1,
  output logic             COUNT_OUT_P2,
  output logic             COUNT_OUT_P1,
  output logic             CLOCK_1,
  output logic             TIMER_BUSY,
  output logic [SEC_W-1:0] SEC_REMAIN
);

  localparam logic [SEC_W-1:0] LOAD_P2 = SEC_W'(DELAY_P2_SEC);
  localparam logic [SEC_W-1:0] LOAD_P1 = SEC_W'(DELAY_P1_SEC);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] sec_nxt;
  logic             running;
  logic             abort;
  logic             tick;
  logic             half_tc;
  logic             clk1;

  assign running = (state == RUN_P2) || (state == RUN_P1);
  assign abort   = ((state == RUN_P2) && !ENABLE_COUNT_P2) ||
                   ((state == RUN_P1) && !ENABLE_COUNT_P1);

  // Prescaler sits at zero whenever no delay is counting.
  alarm_tick_gen #(.MOD(CLK_HZ)) u_pre (
    .CLOCK_IN (CLOCK_IN),
    .RESET    (RESET),
    .clr      (!running || abort),
    .en       (running),
    .tc       (tick)
  );

  alarm_tick_gen #(.MOD(CLK_HZ / 2)) u_half (
    .CLOCK_IN (CLOCK_IN),
    .RESET    (RESET),
    .clr      (1'b0),
    .en       (1'b1),
    .tc       (half_tc)
  );

  always_ff @(posedge CLOCK_IN or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      sec   <= '0;
      clk1  <= 1'b0;
    end else begin
      state <= state_nxt;
      sec   <= sec_nxt;
      if (half_tc) clk1 <= ~clk1;
    end
  end

  always_comb begin
    state_nxt = state;
    sec_nxt   = sec;
    unique case (state)
      IDLE: begin
        if (ENABLE_COUNT_P2) begin
          state_nxt = RUN_P2;
          sec_nxt   = LOAD_P2;
        end else if (ENABLE_COUNT_P1) begin
          state_nxt = RUN_P1;
          sec_nxt   = LOAD_P1;
        end
      end
      RUN_P2, RUN_P1: begin
        if (abort) begin
          state_nxt = IDLE;
          sec_nxt   = '0;
        end else if (tick) begin
          if (sec == SEC_ONE) begin
            state_nxt = (state == RUN_P2) ? DONE_P2 : DONE_P1;
            sec_nxt   = '0;
          end else begin
            sec_nxt = sec - SEC_ONE;
          end
        end
      end
      DONE_P2: if (!ENABLE_COUNT_P2) state_nxt = IDLE;
      DONE_P1: if (!ENABLE_COUNT_P1) state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        sec_nxt   = '0;
      end
    endcase
  end

  assign COUNT_OUT_P2 = (state == DONE_P2);
  assign COUNT_OUT_P1 = (state == DONE_P1);
  assign TIMER_BUSY   = running;
  assign SEC_REMAIN   = running ? sec : '0;
  assign CLOCK_1      = clk1;

endmodule

// File: tb/tb_alarm_delay_scheduler.sv
// Bench for alarm_delay_scheduler at CLK_HZ = 4: completion
// events are scoreboarded by id and due edge number.
module tb_alarm_delay_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_p2 = 1'b0;
  logic       en_p1 = 1'b0;
  logic       out_p2;
  logic       out_p1;
  logic       clk1;
  logic       busy;
  logic [3:0] sec;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int run_edges = 0;
  logic p2_q = 1'b0;
  logic p1_q = 1'b0;

  typedef struct {
    int id;
    int due;
  } ev_t;
  ev_t sb[$];

  alarm_delay_scheduler #(
    .CLK_HZ       (4),
    .DELAY_P2_SEC (5),
    .DELAY_P1_SEC (10)
  ) dut (
    .CLOCK_IN        (clk),
    .RESET           (rst),
    .ENABLE_COUNT_P2 (en_p2),
    .ENABLE_COUNT_P1 (en_p1),
    .COUNT_OUT_P2    (out_p2),
    .COUNT_OUT_P1    (out_p1),
    .CLOCK_1         (clk1),
    .TIMER_BUSY      (busy),
    .SEC_REMAIN      (sec)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges++;

  always @(posedge clk or posedge rst) begin
    if (rst) run_edges = 0;
    else run_edges++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, got, exp, edges);
    end
  endtask

  task automatic sb_push(input int id, input int due);
    ev_t e;
    e.id = id;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int id);
    ev_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected", id, 0);
    end else begin
      e = sb.pop_front();
      chk("sb_id", id, e.id);
      chk("sb_cycle", edges, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("clock_1", int'(clk1), (run_edges >> 1) & 1);
      if (out_p2 && !p2_q) sb_pop(2);
      if (out_p1 && !p1_q) sb_pop(1);
    end
    p2_q = out_p2;
    p1_q = out_p1;
  end

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_p2"}, int'(out_p2), 0);
    chk({tag, "_p1"}, int'(out_p1), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sec"}, int'(sec), 0);
  endtask

  initial begin
    // 1: reset, then idle
    repeat (3) @(negedge clk);
    chk_quiet("rst");
    chk("rst_clk1", int'(clk1), 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk_quiet("idle");
    end

    // 2: P2 delay with SEC_REMAIN stepping
    en_p2 = 1'b1;
    sb_push(2, edges + 1 + 20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("p2_busy", int'(busy), 1);
      chk("p2_sec", int'(sec), 5 - i / 4);
    end
    @(negedge clk);
    chk("p2_done", int'(out_p2), 1);
    chk("p2_done_busy", int'(busy), 0);
    chk("p2_done_sec", int'(sec), 0);
    repeat (3) @(negedge clk);
    chk("p2_hold", int'(out_p2), 1);
    en_p2 = 1'b0;
    @(negedge clk);
    chk_quiet("p2_drop");

    // 3: P1 delay, P2 output must stay low
    en_p1 = 1'b1;
    sb_push(1, edges + 1 + 40);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("p1_sec", int'(sec), 10 - i / 4);
      chk("p1_out_p2", int'(out_p2), 0);
    end
    @(negedge clk);
    chk("p1_done", int'(out_p1), 1);
    en_p1 = 1'b0;
    @(negedge clk);
    chk_quiet("p1_drop");

    // 4: abort after 13 cycles, then full restart
    en_p1 = 1'b1;
    repeat (13) @(negedge clk);
    chk("abort_busy_pre", int'(busy), 1);
    en_p1 = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
    en_p1 = 1'b1;
    sb_push(1, edges + 1 + 40);
    @(negedge clk);
    chk("restart_sec", int'(sec), 10);
    wait_done(60);
    en_p1 = 1'b0;
    @(negedge clk);
    chk_quiet("restart_drop");

    // 5: simultaneous requests, P2 wins, P1 follows
    en_p2 = 1'b1;
    en_p1 = 1'b1;
    sb_push(2, edges + 1 + 20);
    @(negedge clk);
    chk("sim_busy", int'(busy), 1);
    chk("sim_sec", int'(sec), 5);
    wait_done(40);
    @(negedge clk);
    en_p2 = 1'b0;
    sb_push(1, edges + 2 + 40);
    @(negedge clk);
    chk("sim_idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("sim_p1_sec", int'(sec), 10);
    wait_done(60);
    en_p1 = 1'b0;
    @(negedge clk);
    chk_quiet("sim_drop");

    // 6: asynchronous reset mid-run
    en_p2 = 1'b1;
    sb_push(2, edges + 1 + 20);
    for (int i = 0; i < 30 && sec != 4'd3; i++) @(negedge clk);
    chk("ar_sec_pre", int'(sec), 3);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk_quiet("ar");
    chk("ar_clk1", int'(clk1), 0);
    #1 rst = 1'b0;
    sb_push(2, edges + 1 + 20);
    @(negedge clk);
    chk("ar_restart_sec", int'(sec), 5);
    wait_done(40);
    en_p2 = 1'b0;
    @(negedge clk);
    chk_quiet("ar_drop");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_delay_scheduler.md
Name: alarm_delay_scheduler

Overview:
- Owns the single shared seconds timer behind the home alarm FSM's two delay requests: 5 s exit delay (P2) and 10 s siren hold (P1).
- Takes the FSM's ENABLE_COUNT_P2/ENABLE_COUNT_P1 levels, arbitrates them onto one prescaler and seconds down-counter, and returns COUNT_OUT_P2/COUNT_OUT_P1.
- Also generates the free-running 1 Hz CLOCK_1 used for the strobe LED.
- Sits between the 50 MHz board clock and the alarm FSM; replaces separate external counters.

Parameters:
- CLK_HZ, 50000000, input clock cycles per second. Must be even and ≥2; benches use 4.
- DELAY_P2_SEC, 5, exit-delay length in seconds, range 1..15.
- DELAY_P1_SEC, 10, siren-hold length in seconds, range 1..15.

Ports:
- CLOCK_IN  input  1  system clock, rising-edge
- RESET  input  1  asynchronous, active-high reset
- ENABLE_COUNT_P2  input  1  level request for the P2 delay
- ENABLE_COUNT_P1  input  1  level request for the P1 delay
- COUNT_OUT_P2  output  1  P2 delay complete, held while the request stays high
- COUNT_OUT_P1  output  1  P1 delay complete, held while the request stays high
- CLOCK_1  output  1  1 Hz square wave, 50% duty
- TIMER_BUSY  output  1  shared timer counting (RUN_P2 or RUN_P1)
- SEC_REMAIN  output  4  seconds left in the active delay; 0 otherwise

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high; clock port CLOCK_IN, reset port RESET.
- Reset values: state IDLE, prescaler 0, seconds counter 0, CLOCK_1 divider 0. All outputs 0, including CLOCK_1.
- RESET asserted mid-delay aborts the delay immediately with no completion pulse.
- CLOCK_1 divider:
  - Independent free-running counter 0..CLK_HZ/2-1.
  - CLOCK_1 toggles on each wrap.
  - Never gated by the FSM.
- FSM states: IDLE, RUN_P2, RUN_P1, DONE_P2, DONE_P1. All outputs are Moore (registered state only).
- IDLE:
  - P2 high → RUN_P2, loading sec = DELAY_P2_SEC and pre = 0.
  - Else P1 high → RUN_P1, loading DELAY_P1_SEC.
  - Both high in the same cycle → P2 wins; P1 is not queued and is serviced only if still high when IDLE is next reached.
- RUN_x:
  - Each cycle pre increments. At pre == CLK_HZ-1 a tick occurs: pre ← 0, sec ← sec-1.
  - Tick with sec == 1 → DONE_x, sec ← 0.
  - Own enable sampled low → IDLE the next edge, pre and sec cleared, no COUNT_OUT.
  - The other requester is ignored: no preemption.
- DONE_x: COUNT_OUT_x = 1 while own enable is high. Enable low → IDLE.
- Latency: enable first sampled high at edge k → COUNT_OUT_x high after edge k + DELAY_x_SEC·CLK_HZ.
- Leaving a state:
  - DONE→IDLE costs 1 cycle; a new request is accepted at the following edge.
  - Abort→IDLE likewise costs 1 cycle.
- Output values:
  - SEC_REMAIN = sec in RUN_x; 0 in IDLE and DONE_x.
  - TIMER_BUSY = 1 only in RUN_x.
- Width rules:
  - Prescaler width is clog2(CLK_HZ); seconds counter is 4 bits unsigned.
  - sec never underflows because the DONE transition fires at sec == 1.
- Re-request: enable toggling low→high after DONE restarts the full delay from the top.

Decomposition:
- Shared package alarm_pkg holds:
  - state encodings (3-bit, IDLE = 3'b000);
  - CLK_HZ default;
  - delay defaults;
  - SEC_W = 4.
- One sub-module, alarm_tick_gen: parameterised modulo counter with clear/enable and a terminal-count pulse.
  - Instanced twice: once as the delay prescaler (mod CLK_HZ, cleared on load/abort) and once as the CLOCK_1 half-period divider (mod CLK_HZ/2, free-running).

Test Plan (all with CLK_HZ = 4):
1. Reset then idle: RESET high for 3 cycles, release, no requests → all outputs 0; CLOCK_1 toggles every 2 cycles starting low.
2. P2 delay: ENABLE_COUNT_P2 high at edge k and held → SEC_REMAIN steps 5,4,3,2,1 at 4-cycle spacing; COUNT_OUT_P2 rises after edge k+20. Dropping the enable → COUNT_OUT_P2 low and state IDLE one edge later.
3. P1 delay: same flow with ENABLE_COUNT_P1 → COUNT_OUT_P1 rises after edge k+40; COUNT_OUT_P2 stays 0 throughout.
4. Abort: P1 high, dropped after 13 cycles → TIMER_BUSY falls next edge, SEC_REMAIN = 0, no COUNT_OUT_P1 pulse. Re-raising P1 gives a full 40-cycle delay.
5. Simultaneous request: P2 and P1 rise in the same cycle → RUN_P2 is entered. After P2 completes and drops, P1 (still high) starts 1 cycle after IDLE and completes 40 cycles later.
6. Async reset mid-run: RESET pulsed between clock edges during RUN_P2 at SEC_REMAIN = 3 → outputs clear immediately, before the next edge; after release with P2 high, the full 20-cycle delay is required.
